// File: rtl/reg_file_pkg.sv
// Shared types and defaults for the multi-read-port register file.
// The address width is always derived from the register count with rf_aw().
package reg_file_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } rf_state_e;

  localparam int XLEN_DEF  = 64;
  localparam int NREGS_DEF = 32;
  localparam int NRD_DEF   = 2;

  function automatic int rf_aw(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/reg_file_mp_rd_port.sv
// One combinational read port: array select, write bypass and pending select.
module rf_read_port #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic [AW-1:0]         rd_addr_i,
  input  logic [NREGS*XLEN-1:0] mem_i,
  input  logic [NREGS-1:0]      pend_i,
  input  logic                  byp_en_i,
  input  logic [AW-1:0]         wr_addr_i,
  input  logic [XLEN-1:0]       wr_data_i,
  output logic [XLEN-1:0]       rd_data_o,
  output logic                  rd_pending_o
);

  logic byp_hit;

  // Register 0 is never bypassed so it always reads as the stored zero.
  assign byp_hit = byp_en_i && (wr_addr_i == rd_addr_i) && (rd_addr_i != '0);

  always_comb begin
    rd_data_o    = mem_i[XLEN*int'(rd_addr_i) +: XLEN];
    rd_pending_o = pend_i[rd_addr_i];
    if (byp_hit) begin
      rd_data_o    = wr_data_i;
      rd_pending_o = 1'b0;
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with hardwired-zero x0, write bypass,
// per-register pending bits and a sequential whole-file clear engine.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEF,
  parameter  int NREGS = NREGS_DEF,
  parameter  int NRD   = NRD_DEF,
  localparam int AW    = rf_aw(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   rd_addr_i,
  output logic [NRD*XLEN-1:0] rd_data_o,
  output logic [NRD-1:0]      rd_pending_o,
  input  logic                wr_en_i,
  input  logic [AW-1:0]       wr_addr_i,
  input  logic [XLEN-1:0]     wr_data_i,
  input  logic                rsv_en_i,
  input  logic [AW-1:0]       rsv_addr_i,
  input  logic                clr_req_i,
  output logic                clr_busy_o,
  output logic                clr_done_o
);

  rf_state_e         state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic              done_q, done_d;
  logic [NREGS-1:0]  pend_q, pend_d;
  logic [XLEN-1:0]   mem_q [NREGS];
  logic [NREGS*XLEN-1:0] mem_flat;

  logic wr_fire, rsv_fire, byp_en, idx_last;

  assign wr_fire  = (state_q == IDLE) && wr_en_i  && (wr_addr_i  != '0);
  assign rsv_fire = (state_q == IDLE) && rsv_en_i && (rsv_addr_i != '0);
  assign idx_last = (idx_q == AW'(NREGS - 1));

  // Bypass is suppressed during reset so every address reads zero.
  assign byp_en   = rst_n && (state_q == IDLE) && wr_en_i;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clr_req_i) begin
          state_d = CLEAR;
          idx_d   = AW'(1);
        end
      end
      CLEAR: begin
        if (idx_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A reserve in the same cycle as a write to the same register wins.
  always_comb begin
    pend_d = pend_q;
    if (state_q == CLEAR) begin
      pend_d[idx_q] = 1'b0;
    end else begin
      if (wr_fire)  pend_d[wr_addr_i]  = 1'b0;
      if (rsv_fire) pend_d[rsv_addr_i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= AW'(1);
      done_q  <= 1'b0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      pend_q  <= pend_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else if (state_q == CLEAR) begin
      mem_q[idx_q] <= '0;
    end else if (wr_fire) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_flat
    assign mem_flat[g*XLEN +: XLEN] = mem_q[g];
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    rf_read_port #(
      .XLEN  (XLEN),
      .NREGS (NREGS),
      .AW    (AW)
    ) u_rd (
      .rd_addr_i    (rd_addr_i[p*AW +: AW]),
      .mem_i        (mem_flat),
      .pend_i       (pend_q),
      .byp_en_i     (byp_en),
      .wr_addr_i    (wr_addr_i),
      .wr_data_i    (wr_data_i),
      .rd_data_o    (rd_data_o[p*XLEN +: XLEN]),
      .rd_pending_o (rd_pending_o[p])
    );
  end

  assign clr_busy_o = (state_q == CLEAR);
  assign clr_done_o = done_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed and model-checked bench: default 32x64 two-port file plus an
// 8x32 four-port instance driven with random traffic.
module tb_reg_file_mp;

  localparam int XA = 64, NA = 32, RA = 2, WA = 5;
  localparam int XB = 32, NB = 8,  RB = 4, WB = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [RA*WA-1:0] a_rd_addr;
  logic [RA*XA-1:0] a_rd_data;
  logic [RA-1:0]    a_rd_pend;
  logic             a_wr_en, a_rsv_en, a_clr_req, a_clr_busy, a_clr_done;
  logic [WA-1:0]    a_wr_addr, a_rsv_addr;
  logic [XA-1:0]    a_wr_data;

  logic [RB*WB-1:0] b_rd_addr;
  logic [RB*XB-1:0] b_rd_data;
  logic [RB-1:0]    b_rd_pend;
  logic             b_wr_en, b_rsv_en, b_clr_req, b_clr_busy, b_clr_done;
  logic [WB-1:0]    b_wr_addr, b_rsv_addr;
  logic [XB-1:0]    b_wr_data;

  reg_file_mp u_dut_a (
    .clk (clk), .rst_n (rst_n),
    .rd_addr_i (a_rd_addr), .rd_data_o (a_rd_data), .rd_pending_o (a_rd_pend),
    .wr_en_i (a_wr_en), .wr_addr_i (a_wr_addr), .wr_data_i (a_wr_data),
    .rsv_en_i (a_rsv_en), .rsv_addr_i (a_rsv_addr),
    .clr_req_i (a_clr_req), .clr_busy_o (a_clr_busy), .clr_done_o (a_clr_done)
  );

  reg_file_mp #(.XLEN(XB), .NREGS(NB), .NRD(RB)) u_dut_b (
    .clk (clk), .rst_n (rst_n),
    .rd_addr_i (b_rd_addr), .rd_data_o (b_rd_data), .rd_pending_o (b_rd_pend),
    .wr_en_i (b_wr_en), .wr_addr_i (b_wr_addr), .wr_data_i (b_wr_data),
    .rsv_en_i (b_rsv_en), .rsv_addr_i (b_rsv_addr),
    .clr_req_i (b_clr_req), .clr_busy_o (b_clr_busy), .clr_done_o (b_clr_done)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic a_idle();
    a_wr_en = 1'b0; a_wr_addr = '0; a_wr_data = '0;
    a_rsv_en = 1'b0; a_rsv_addr = '0; a_clr_req = 1'b0;
  endtask

  task automatic b_idle();
    b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0;
    b_rsv_en = 1'b0; b_rsv_addr = '0; b_clr_req = 1'b0; b_rd_addr = '0;
  endtask

  task automatic a_rd(input logic [WA-1:0] p0, input logic [WA-1:0] p1);
    a_rd_addr = {p1, p0};
  endtask

  task automatic a_wr(input logic [WA-1:0] ad, input logic [XA-1:0] d);
    a_wr_en = 1'b1; a_wr_addr = ad; a_wr_data = d;
  endtask

  function automatic logic [XA-1:0] a_d(input int p);
    return a_rd_data[p*XA +: XA];
  endfunction

  logic [XB-1:0] m_mem [NB];
  logic [NB-1:0] m_pend;
  int busy_n, done_n;
  logic [WB-1:0] ra;
  logic          hit;

  initial begin
    a_idle(); b_idle(); a_rd(0, 0);
    for (int i = 0; i < NB; i++) m_mem[i] = '0;
    m_pend = '0;

    // Reset: bypass gated off, outputs quiet
    a_wr(5, 64'h55); a_rd(5, 5);
    #12;
    chk("rst_rd0", a_d(0), 0);
    chk("rst_rd1", a_d(1), 0);
    chk("rst_pend", {62'b0, a_rd_pend}, 0);
    @(negedge clk); rst_n = 1'b1; a_idle();
    #1;
    chk("rel_busy", {63'b0, a_clr_busy}, 0);
    chk("rel_done", {63'b0, a_clr_done}, 0);

    for (int ad = 0; ad < NA; ad++) begin
      @(negedge clk); a_rd(WA'(ad), WA'(NA-1-ad)); #1;
      chk("rst_all_d0", a_d(0), 0);
      chk("rst_all_d1", a_d(1), 0);
      chk("rst_all_p", {62'b0, a_rd_pend}, 0);
    end

    // x0 stays zero
    @(negedge clk); a_wr(0, 64'hDEAD); a_rd(0, 0); #1;
    chk("x0_same", a_d(0), 0);
    @(negedge clk); a_idle(); #1;
    chk("x0_after", a_d(0), 0);
    chk("x0_pend", {62'b0, a_rd_pend}, 0);

    // Same-cycle bypass on both ports
    @(negedge clk); a_wr(5, 64'h1234_5678_9ABC_DEF0); a_rd(5, 5); #1;
    chk("byp_p0", a_d(0), 64'h1234_5678_9ABC_DEF0);
    chk("byp_p1", a_d(1), 64'h1234_5678_9ABC_DEF0);
    chk("byp_pend", {62'b0, a_rd_pend}, 0);
    @(negedge clk); a_idle(); #1;
    chk("stored_p0", a_d(0), 64'h1234_5678_9ABC_DEF0);
    chk("stored_p1", a_d(1), 64'h1234_5678_9ABC_DEF0);

    // Reserve / write interaction on x7
    @(negedge clk); a_rsv_en = 1'b1; a_rsv_addr = 7; a_rd(0, 7); #1;
    chk("rsv_same", {63'b0, a_rd_pend[1]}, 0);
    @(negedge clk); a_idle(); a_rd(7, 7); #1;
    chk("rsv_next", {62'b0, a_rd_pend}, 2'b11);
    @(negedge clk); a_wr(7, 64'h42); #1;
    chk("wr7_byp_d", a_d(1), 64'h42);
    chk("wr7_byp_p", {63'b0, a_rd_pend[1]}, 0);
    @(negedge clk); a_idle(); #1;
    chk("wr7_d", a_d(1), 64'h42);
    chk("wr7_p", {62'b0, a_rd_pend}, 0);

    // Reserve and write x9 together: producer wins
    @(negedge clk); a_wr(9, 64'h99); a_rsv_en = 1'b1; a_rsv_addr = 9; a_rd(9, 9); #1;
    chk("x9_byp_p", {62'b0, a_rd_pend}, 0);
    @(negedge clk); a_idle(); #1;
    chk("x9_pend", {63'b0, a_rd_pend[1]}, 1);
    chk("x9_data", a_d(1), 64'h99);

    // Fill x1..x31 with i*0x11, then reserve x12
    for (int i = 1; i < NA; i++) begin
      @(negedge clk); a_wr(WA'(i), 64'(i) * 64'h11);
    end
    @(negedge clk); a_idle(); a_rsv_en = 1'b1; a_rsv_addr = 12;
    @(negedge clk); a_idle(); a_rd(12, 31); #1;
    chk("fill_p12", {63'b0, a_rd_pend[0]}, 1);
    chk("fill_d12", a_d(0), 64'hCC);
    chk("fill_d31", a_d(1), 64'h20F);

    // Clear: 31 busy cycles, mid-clear write and clr_req dropped
    @(negedge clk); a_clr_req = 1'b1; a_rd(3, 31);
    @(negedge clk); a_clr_req = 1'b0;
    busy_n = 0; done_n = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (a_clr_busy) busy_n++;
      if (a_clr_done) done_n++;
      if (c == 0) begin
        chk("clr_raw31", a_d(1), 64'h20F);
        chk("clr_raw3", a_d(0), 64'h33);
      end
      if (c == 4) begin
        a_wr(3, 64'hBAD); #1;
        chk("clr_nobyp", a_d(0), 0);
      end
      if (c == 5) a_idle();
      if (c == 6) a_clr_req = 1'b1;
      if (c == 7) a_clr_req = 1'b0;
      @(negedge clk);
    end
    chk("clr_busy_cyc", 64'(busy_n), 31);
    chk("clr_done_cnt", 64'(done_n), 1);
    for (int ad = 0; ad < NA; ad++) begin
      a_rd(WA'(ad), WA'(ad)); #1;
      chk("post_clr_d", a_d(0), 0);
      chk("post_clr_p", {63'b0, a_rd_pend[0]}, 0);
    end
    @(negedge clk); a_wr(4, 64'hABC);
    @(negedge clk); a_idle(); a_rd(4, 4); #1;
    chk("post_clr_wr", a_d(1), 64'hABC);

    // Asynchronous reset while the clear index is 10
    @(negedge clk); a_wr(20, 64'h77);
    @(negedge clk); a_wr(25, 64'h88);
    @(negedge clk); a_idle(); a_clr_req = 1'b1;
    @(negedge clk); a_clr_req = 1'b0;
    repeat (9) @(negedge clk);
    #1;
    chk("mid_busy", {63'b0, a_clr_busy}, 1);
    rst_n = 1'b0; a_wr(20, 64'h5); a_rd(20, 25); #1;
    chk("mid_rst_busy", {63'b0, a_clr_busy}, 0);
    chk("mid_rst_done", {63'b0, a_clr_done}, 0);
    chk("mid_rst_d0", a_d(0), 0);
    chk("mid_rst_d1", a_d(1), 0);
    @(negedge clk); rst_n = 1'b1; a_idle(); #1;
    @(negedge clk); #1;
    chk("mid_rel_d0", a_d(0), 0);
    chk("mid_rel_d1", a_d(1), 0);
    chk("mid_rel_busy", {63'b0, a_clr_busy}, 0);

    // Random traffic on the 8x32 four-port instance
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      b_wr_en    = 1'($urandom_range(0, 1));
      b_wr_addr  = WB'($urandom_range(0, NB-1));
      b_wr_data  = $urandom;
      b_rsv_en   = ($urandom_range(0, 2) == 0);
      b_rsv_addr = WB'($urandom_range(0, NB-1));
      for (int p = 0; p < RB; p++) b_rd_addr[p*WB +: WB] = WB'($urandom_range(0, NB-1));
      #1;
      for (int p = 0; p < RB; p++) begin
        ra  = b_rd_addr[p*WB +: WB];
        hit = b_wr_en && (b_wr_addr == ra) && (ra != 0);
        chk("rnd_d", 64'(b_rd_data[p*XB +: XB]), 64'(hit ? b_wr_data : m_mem[ra]));
        chk("rnd_p", {63'b0, b_rd_pend[p]}, {63'b0, hit ? 1'b0 : m_pend[ra]});
      end
      if (b_wr_en && b_wr_addr != 0) begin
        m_mem[b_wr_addr]  = b_wr_data;
        m_pend[b_wr_addr] = 1'b0;
      end
      if (b_rsv_en && b_rsv_addr != 0) m_pend[b_rsv_addr] = 1'b1;
    end
    @(negedge clk); b_idle(); b_clr_req = 1'b1;
    @(negedge clk); b_clr_req = 1'b0;
    busy_n = 0; done_n = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (b_clr_busy) busy_n++;
      if (b_clr_done) done_n++;
      @(negedge clk);
    end
    chk("b_busy_cyc", 64'(busy_n), 7);
    chk("b_done_cnt", 64'(done_n), 1);
    for (int g = 0; g < 2; g++) begin
      for (int p = 0; p < RB; p++) b_rd_addr[p*WB +: WB] = WB'(g*RB + p);
      #1;
      for (int p = 0; p < RB; p++) begin
        chk("b_clr_d", 64'(b_rd_data[p*XB +: XB]), 0);
        chk("b_clr_p", {63'b0, b_rd_pend[p]}, 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
